// File: rtl/rca_pkg.sv
// rca_pkg -- shared definitions for the rca_accum slice.
//   state_t      : accumulator FSM states (ACCUM, DONE)
//   WIDTH_*      : supported operand/accumulator widths
package rca_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam int unsigned WIDTH_8  = 8;
    localparam int unsigned WIDTH_16 = 16;
    localparam int unsigned WIDTH_32 = 32;
    localparam int unsigned WIDTH_64 = 64;

endpackage

// File: rtl/rca.sv
// rca -- N-bit ripple-carry adder built from a chain of full adders.
// Ports:
//   A, B  : N-bit addends
//   Cin   : carry in
//   Sum   : N-bit sum
//   Cout  : carry out of the most significant bit
module rca #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] Sum,
    output logic         Cout
);

    logic [N:0] carry;

    assign carry[0] = Cin;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_fa
            assign Sum[i]     = A[i] ^ B[i] ^ carry[i];
            assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
    endgenerate

    assign Cout = carry[N];

endmodule

// File: rtl/rca_accum.sv
// rca_accum -- sums BATCH unsigned operands through one rca instance and
// presents the batch result with a valid/ready handshake.
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : operand valid
//   in_ready   : operand can be accepted this cycle (high in ACCUM)
//   in_data    : N-bit unsigned operand
//   out_valid  : batch result available (high in DONE)
//   out_ready  : downstream consumes the result
//   out_sum    : accumulated batch sum (registered)
//   out_ovf    : sticky carry-out flag for the batch (registered)
// Build option:
//   RCA_ACCUM_SAT_EN : when defined, a carry-out saturates the accumulator
//                      to all-ones instead of wrapping modulo 2^N.
//
// state | meaning
// ------+--------------------------------------------------
// ACCUM | collecting operands, in_ready=1, out_valid=0
// DONE  | holding result, in_ready=0, out_valid=1
module rca_accum
    import rca_pkg::*;
#(
    parameter int N     = WIDTH_8,
    parameter int BATCH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_ovf
);

    localparam logic [0:0] S_ACCUM = 1'(ACCUM);
    localparam logic [0:0] S_DONE  = 1'(DONE);

    // BATCH=1 still needs a one-bit counter; it simply never advances.
    localparam int CNT_W = (BATCH > 1) ? $clog2(BATCH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BATCH - 1);

    logic [0:0]       state;
    logic [N-1:0]     acc;
    logic             ovf;
    logic [CNT_W-1:0] cnt;

    logic [N-1:0]     sum;
    logic             cout;
    logic [N-1:0]     acc_nxt;
    logic             accept;

    rca #(.N(N)) u_rca (
        .A    (acc),
        .B    (in_data),
        .Cin  (1'b0),
        .Sum  (sum),
        .Cout (cout)
    );

`ifdef RCA_ACCUM_SAT_EN
    // Once acc is all-ones any non-zero operand carries out again, and a zero
    // operand leaves it unchanged, so saturation holds for the rest of the batch.
    assign acc_nxt = cout ? {N{1'b1}} : sum;
`else
    assign acc_nxt = sum;
`endif

    assign in_ready  = (state == S_ACCUM);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign out_sum   = acc;
    assign out_ovf   = ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_ACCUM;
            acc   <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                S_ACCUM: begin
                    if (accept) begin
                        acc <= acc_nxt;
                        ovf <= ovf | cout;
                        if (cnt == CNT_LAST) begin
                            // counter is held here and cleared when the result is taken
                            state <= S_DONE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_ACCUM;
                        acc   <= '0;
                        ovf   <= 1'b0;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= S_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rca_accum.sv
module tb_rca_accum;

    typedef struct {
        logic [7:0] sum;
        logic       ovf;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_sum;
    logic       out_ovf;

    rca_accum #(.N(8), .BATCH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    // BATCH=1 instances at every legal width share one stimulus stream
    logic        in_valid_w;
    logic [63:0] data_w;
    logic        out_ready_w;
    logic [3:0]  ir_w, ov_w, ovf_w;
    logic [7:0]  s8;
    logic [15:0] s16;
    logic [31:0] s32;
    logic [63:0] s64;
    logic [63:0] sum_w [4];
    logic [63:0] mask_w [4];

    rca_accum #(.N(8), .BATCH(1)) dut_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(ir_w[0]),
        .in_data(data_w[7:0]), .out_valid(ov_w[0]), .out_ready(out_ready_w),
        .out_sum(s8), .out_ovf(ovf_w[0]));
    rca_accum #(.N(16), .BATCH(1)) dut_w16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(ir_w[1]),
        .in_data(data_w[15:0]), .out_valid(ov_w[1]), .out_ready(out_ready_w),
        .out_sum(s16), .out_ovf(ovf_w[1]));
    rca_accum #(.N(32), .BATCH(1)) dut_w32 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(ir_w[2]),
        .in_data(data_w[31:0]), .out_valid(ov_w[2]), .out_ready(out_ready_w),
        .out_sum(s32), .out_ovf(ovf_w[2]));
    rca_accum #(.N(64), .BATCH(1)) dut_w64 (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(ir_w[3]),
        .in_data(data_w), .out_valid(ov_w[3]), .out_ready(out_ready_w),
        .out_sum(s64), .out_ovf(ovf_w[3]));

    assign sum_w[0] = {56'b0, s8};
    assign sum_w[1] = {48'b0, s16};
    assign sum_w[2] = {32'b0, s32};
    assign sum_w[3] = s64;
    assign mask_w[0] = 64'h0000_0000_0000_00FF;
    assign mask_w[1] = 64'h0000_0000_0000_FFFF;
    assign mask_w[2] = 64'h0000_0000_FFFF_FFFF;
    assign mask_w[3] = 64'hFFFF_FFFF_FFFF_FFFF;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: a batch is the plain integer sum of its operands; a carry
    // happened iff that sum reaches 256.
    function automatic res_t model(input int unsigned ops[$]);
        res_t r;
        int unsigned total;
        total = 0;
        foreach (ops[i]) total += ops[i];
        r.ovf = (total > 255);
`ifdef RCA_ACCUM_SAT_EN
        r.sum = r.ovf ? 8'hFF : 8'(total);
`else
        r.sum = 8'(total % 256);
`endif
        return r;
    endfunction

    res_t        exp_q[$];
    int unsigned batch_ops[$];
    int          accepts   = 0;
    bit          rise_due  = 0;
    bit          clear_due = 0;
    bit          rst_due   = 0;
    bit          w_pending = 0;
    logic [63:0] w_exp     = '0;

    // Monitor + scoreboard for the BATCH=4 instance. First check what the
    // outputs show after the last rising edge, then predict the coming edge.
    always @(negedge clk) begin
        if (rst_due) begin
            check("reset_in_ready", 64'(in_ready), 64'd1);
            check("reset_out_valid", 64'(out_valid), 64'd0);
            check("reset_out_sum", 64'(out_sum), 64'd0);
            check("reset_out_ovf", 64'(out_ovf), 64'd0);
            rst_due = 0;
        end
        if (rise_due) begin
            check("valid_latency", 64'(out_valid), 64'd1);
            rise_due = 0;
        end
        if (clear_due) begin
            check("consume_to_accum", 64'({out_valid, in_ready}), 64'b01);
            check("consume_clears_sum", 64'(out_sum), 64'd0);
            check("consume_clears_ovf", 64'(out_ovf), 64'd0);
            clear_due = 0;
        end
        check("ready_is_not_valid", 64'(in_ready), 64'(!out_valid));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%0h expected=none t=%0t", out_sum, $time);
            end else begin
                check("out_sum", 64'(out_sum), 64'(exp_q[0].sum));
                check("out_ovf", 64'(out_ovf), 64'(exp_q[0].ovf));
                if (out_ready && !rst) begin
                    void'(exp_q.pop_front());
                    clear_due = 1;
                end
            end
        end
        if (rst) begin
            batch_ops.delete();
            exp_q.delete();
            rise_due  = 0;
            clear_due = 0;
            rst_due   = 1;
        end else if (in_valid && in_ready) begin
            batch_ops.push_back(int'(in_data));
            accepts++;
            if (batch_ops.size() == 4) begin
                exp_q.push_back(model(batch_ops));
                batch_ops.delete();
                rise_due = 1;
            end
        end
    end

    // BATCH=1 instances: one result outstanding at most, equal to the operand.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            check($sformatf("w%0d_out_valid", k), 64'(ov_w[k]), 64'(w_pending));
            check($sformatf("w%0d_in_ready", k), 64'(ir_w[k]), 64'(!w_pending));
            if (w_pending) begin
                check($sformatf("w%0d_out_sum", k), sum_w[k], w_exp & mask_w[k]);
                check($sformatf("w%0d_out_ovf", k), 64'(ovf_w[k]), 64'd0);
            end
        end
        if (rst) w_pending = 0;
        else if (w_pending && out_ready_w) w_pending = 0;
        else if (!w_pending && in_valid_w) begin
            w_pending = 1;
            w_exp     = data_w;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=%0d expected=<50 t=%0t", n, $time);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=%0d expected=<100 t=%0t", n, $time);
        end
        tick();
    endtask

    initial begin
        bit pat [7];
        int a0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        in_valid_w  = 1'b0;
        data_w      = '0;
        out_ready_w = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // wide instances: all-ones first, then random with backpressure
        in_valid_w = 1'b1;
        data_w     = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        in_valid_w = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 60; i++) begin
            in_valid_w  = 1'($urandom_range(0, 1));
            data_w      = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                      : {$urandom, $urandom};
            out_ready_w = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid_w  = 1'b0;
        out_ready_w = 1'b1;

        // 1,2,3,4 -> 0x0A, no carry
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        wait_idle();

        // carry-out case: wraps to 0x00 (or saturates to 0xFF)
        send(8'hFF); send(8'h01); send(8'h00); send(8'h00);
        wait_idle();

        // backpressure with in_valid held high in DONE
        out_ready = 1'b0;
        send(8'h10); send(8'h20); send(8'h30); send(8'h40);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_sum", 64'(out_sum), 64'hA0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        wait_idle();

        // gapped input: 4 accepts out of 7 cycles
        pat = '{1, 0, 0, 1, 1, 0, 1};
        a0  = accepts;
        foreach (pat[i]) begin
            in_valid = pat[i];
            in_data  = 8'd5;
            tick();
        end
        in_valid = 1'b0;
        check("gapped_accepts", 64'(accepts - a0), 64'd4);
        wait_idle();

        // reset mid-batch discards 7, 9
        send(8'd7); send(8'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(8'd1); send(8'd1); send(8'd1); send(8'd1);
        wait_idle();

        // reset while a result is pending in DONE
        out_ready = 1'b0;
        send(8'h80); send(8'h80); send(8'h01); send(8'h02);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        wait_idle();

        // randomized traffic with gaps and backpressure
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = ($urandom_range(0, 3) == 0) ? 8'(8'hFF - $urandom_range(0, 3))
                                                    : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        for (int i = 0; i < 4 && batch_ops.size() != 0; i++) send(8'($urandom));
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
